// File: rtl/lbp_pkg.sv
// Shared constants, FSM encoding and border test for the LBP image host.
package lbp_pkg;

    localparam int IMG_W   = 128;
    localparam int IMG_H   = 128;
    localparam int AW      = 14;
    localparam int DW      = 8;
    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_INNER = (IMG_W - 2) * (IMG_H - 2);
    localparam int CW      = $clog2(IMG_W);

    typedef enum logic [2:0] {IDLE, LOAD, SERVE, DUMP, DONE} state_t;

    // IMG_W is a power of 2, so the last column is all ones.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [AW-CW-1:0] row;
        logic [CW-1:0]    col;
        row = addr[AW-1:CW];
        col = addr[CW-1:0];
        return (row == '0) || (row == (AW-CW)'(IMG_H - 1)) || (col == '0) || (col == '1);
    endfunction

endpackage

// File: rtl/lbp_host_ram.sv
// Image-sized storage: one synchronous write port, one asynchronous read port.
module lbp_host_ram #(
    parameter int AW = lbp_pkg::AW,
    parameter int DW = lbp_pkg::DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_img_host.sv
// Memory-side responder for the LBP engine: loads the gray image, serves reads,
// captures LBP writes and streams the result back out after finish.
module lbp_img_host #(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H,
    parameter int AW    = lbp_pkg::AW,
    parameter int DW    = lbp_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_data,
    input  logic          host_stall,
    input  logic [AW-1:0] gray_addr,
    input  logic          gray_req,
    output logic          gray_ready,
    output logic [DW-1:0] gray_data,
    input  logic [AW-1:0] lbp_addr,
    input  logic          lbp_valid,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic [AW-1:0] wr_count,
    output logic          done,
    output logic          err
);
    import lbp_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] INNER_CNT = AW'((IMG_W - 2) * (IMG_H - 2));

    state_t        state, state_nx;
    logic [AW-1:0] ld_ptr;
    logic [AW:0]   dump_ptr;
    logic [DW-1:0] gray_rd, lbp_rd;
    logic [AW-1:0] wr_count_nx;
    logic          gray_we, lbp_we, lbp_border, start_ok;
    logic          dump_entry, dump_fire, dump_load, err_set;

    lbp_host_ram #(.AW(AW), .DW(DW)) u_gray_mem (
        .clk(clk), .we(gray_we), .waddr(ld_ptr), .wdata(load_data),
        .raddr(gray_addr), .rdata(gray_rd)
    );

    lbp_host_ram #(.AW(AW), .DW(DW)) u_lbp_mem (
        .clk(clk), .we(lbp_we), .waddr(lbp_addr), .wdata(lbp_data),
        .raddr(dump_ptr[AW-1:0]), .rdata(lbp_rd)
    );

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign gray_we     = (state == LOAD) && load_valid;
    assign lbp_border  = is_border(lbp_addr);
    assign lbp_we      = (state == SERVE) && lbp_valid && !lbp_border;
    assign dump_entry  = (state == SERVE) && finish;
    assign dump_fire   = dump_valid && dump_ready;
    assign dump_load   = (state == DUMP) && !dump_ptr[AW] && (!dump_valid || dump_ready);
    assign wr_count_nx = (lbp_we && wr_count != '1) ? wr_count + 1'b1 : wr_count;
    // The finish check uses the post-edge count so a write alongside finish is included.
    assign err_set     = (gray_req && state != SERVE)
                       || (lbp_valid && (state != SERVE || lbp_border))
                       || (dump_entry && wr_count_nx != INNER_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (gray_we && ld_ptr == LAST_ADDR) state_nx = SERVE;
            SERVE:   if (finish) state_nx = DUMP;
            DUMP:    if (dump_fire && dump_addr == LAST_ADDR) state_nx = DONE;
            DONE:    if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == LOAD);
        done       = (state == DONE);
        gray_data  = (state == SERVE) ? gray_rd : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_ptr     <= '0;
            wr_count   <= '0;
            err        <= 1'b0;
            gray_ready <= 1'b0;
        end else begin
            gray_ready <= (state_nx == SERVE) && !host_stall;
            if (start_ok) begin
                ld_ptr   <= '0;
                wr_count <= '0;
                err      <= 1'b0;
            end else begin
                if (gray_we) ld_ptr <= ld_ptr + 1'b1;
                wr_count <= wr_count_nx;
                if (err_set) err <= 1'b1;
            end
        end
    end

    // Output register refills from the prefetch address whenever it is empty or draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dump_ptr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else if (dump_entry) begin
            dump_ptr   <= '0;
            dump_valid <= 1'b0;
        end else if (dump_load) begin
            dump_valid <= 1'b1;
            dump_addr  <= dump_ptr[AW-1:0];
            dump_data  <= is_border(dump_ptr[AW-1:0]) ? '0 : lbp_rd;
            dump_ptr   <= dump_ptr + 1'b1;
        end else if (dump_fire) begin
            dump_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lbp_img_host.sv
// Self-checking bench for lbp_img_host: load/serve/write/dump flow with a dump scoreboard.
module tb_lbp_img_host;

    localparam int W       = 128;
    localparam int H       = 128;
    localparam int N       = W * H;
    localparam int N_INNER = (W - 2) * (H - 2);
    localparam int LAST_IN = (H - 2) * W + (W - 2);

    logic        clk = 1'b0;
    logic        reset, start, load_valid, load_ready;
    logic [7:0]  load_data;
    logic        host_stall;
    logic [13:0] gray_addr;
    logic        gray_req, gray_ready;
    logic [7:0]  gray_data;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish, dump_valid, dump_ready;
    logic [13:0] dump_addr;
    logic [7:0]  dump_data;
    logic [13:0] wr_count;
    logic        done, err;

    int checks = 0;
    int failures = 0;

    logic [7:0]  img [N];
    logic [7:0]  lbp_model [N];
    logic [21:0] exp_q [$];

    always #5 clk = ~clk;

    lbp_img_host dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .host_stall(host_stall), .gray_addr(gray_addr), .gray_req(gray_req),
        .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data),
        .finish(finish), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .wr_count(wr_count), .done(done), .err(err)
    );

    function automatic logic border(input int a);
        int r, c;
        r = a / W;
        c = a % W;
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    function automatic logic [7:0] pix(input int kind, input int i);
        logic [31:0] v;
        v = i;
        case (kind)
            0:       return v[7:0];
            1:       return 8'h40;
            default: return 8'hAA;
        endcase
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_pixels(input int n, input int kind, input bit check_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = pix(kind, i);
            img[i]     = pix(kind, i);
            if (check_last && i == n - 1) begin
                @(negedge clk);
                checks++;
                if ({load_ready, gray_ready} !== 2'b10) begin
                    failures++;
                    $display("FAIL last_beat_ready: load_ready,gray_ready=%b want 10", {load_ready, gray_ready});
                end
                checks++;
                if (gray_data !== 8'h00) begin
                    failures++;
                    $display("FAIL gray_data_outside_serve: got %0h want 0", gray_data);
                end
            end
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; host_stall = 1'b0;
        gray_addr = '0; gray_req = 1'b0; lbp_addr = '0; lbp_valid = 1'b0; lbp_data = '0;
        finish = 1'b0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({load_ready, gray_ready, gray_data, dump_valid, dump_addr, dump_data, wr_count, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_values: got %0h want 0",
                     {load_ready, gray_ready, gray_data, dump_valid, dump_addr, dump_data, wr_count, done, err});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_err_outside_serve();
        gray_req = 1'b1;
        @(posedge clk); #1;
        gray_req = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL gray_req_idle_err: got %b want 1", err);
        end
        @(posedge clk); #1;
        start_pulse();
        @(negedge clk);
        checks++;
        if ({load_ready, err, wr_count} !== {1'b1, 1'b0, 14'd0}) begin
            failures++;
            $display("FAIL start_clears: load_ready,err,wr_count=%0h want %0h", {load_ready, err, wr_count}, {1'b1, 15'd0});
        end
    endtask

    task automatic test_load_ramp();
        gray_addr = 14'd129;
        load_pixels(N, 0, 1'b1);
        @(negedge clk);
        checks++;
        if ({load_ready, gray_ready} !== 2'b01) begin
            failures++;
            $display("FAIL serve_entry_ready: load_ready,gray_ready=%b want 01", {load_ready, gray_ready});
        end
    endtask

    task automatic test_gray_read();
        int a;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            a = (k == 0) ? 129 : int'($urandom_range(0, N - 1));
            gray_addr = 14'(a);
            gray_req  = (k % 2 == 1);
            @(negedge clk);
            checks++;
            if (gray_data !== img[a]) begin
                failures++;
                $display("FAIL gray_read[%0d]: got %0h want %0h", a, gray_data, img[a]);
            end
        end
        gray_req = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL gray_req_serve_no_err: got %b want 0", err);
        end
    endtask

    task automatic test_host_stall();
        logic exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int a;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            host_stall = (i < 3);
            a = int'($urandom_range(0, N - 1));
            gray_addr = 14'(a);
            @(negedge clk);
            checks++;
            if (gray_ready !== exp_rdy[i]) begin
                failures++;
                $display("FAIL stall_ready[%0d]: got %b want %b", i, gray_ready, exp_rdy[i]);
            end
            checks++;
            if (gray_data !== img[a]) begin
                failures++;
                $display("FAIL stall_data[%0d]: got %0h want %0h", i, gray_data, img[a]);
            end
        end
        host_stall = 1'b0;
    endtask

    task automatic test_border_write();
        int addrs [2] = '{0, 5 * W + (W - 1)};
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            lbp_valid = 1'b1;
            lbp_addr  = 14'(addrs[k]);
            lbp_data  = 8'h55;
            @(posedge clk); #1;
            lbp_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({err, wr_count} !== {1'b1, 14'd0}) begin
                failures++;
                $display("FAIL border_write[%0d]: err,wr_count=%0h want %0h", addrs[k], {err, wr_count}, {1'b1, 14'd0});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({load_ready, gray_ready, gray_data, dump_valid, wr_count, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_in_serve: got %0h want 0", {load_ready, gray_ready, gray_data, dump_valid, wr_count, done, err});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start_pulse();
        load_pixels(5000, 2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({load_ready, err, wr_count} !== '0) begin
            failures++;
            $display("FAIL reset_in_load: load_ready,err,wr_count=%0h want 0", {load_ready, err, wr_count});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start_pulse();
        @(negedge clk);
        checks++;
        if ({load_ready, err, wr_count} !== {1'b1, 1'b0, 14'd0}) begin
            failures++;
            $display("FAIL restart_after_reset: load_ready,err,wr_count=%0h want %0h", {load_ready, err, wr_count}, {1'b1, 15'd0});
        end
    endtask

    task automatic test_full_run();
        gray_addr = 14'd129;
        load_pixels(N, 1, 1'b1);
        @(negedge clk);
        checks++;
        if ({gray_ready, gray_data} !== {1'b1, 8'h40}) begin
            failures++;
            $display("FAIL const_serve: gray_ready,gray_data=%0h want %0h", {gray_ready, gray_data}, {1'b1, 8'h40});
        end
        gray_addr = 14'd4999;
        #1;
        checks++;
        if (gray_data !== 8'h40) begin
            failures++;
            $display("FAIL reload_overwrites: got %0h want 40", gray_data);
        end
        foreach (lbp_model[a]) lbp_model[a] = 8'h00;
        for (int a = 0; a < N; a++) begin
            if (!border(a)) begin
                lbp_valid = 1'b1;
                lbp_addr  = 14'(a);
                lbp_data  = 8'hFF;
                finish    = (a == LAST_IN);
                lbp_model[a] = 8'hFF;
                @(posedge clk); #1;
            end
        end
        lbp_valid = 1'b0;
        finish    = 1'b0;
        for (int a = 0; a < N; a++)
            exp_q.push_back({14'(a), border(a) ? 8'h00 : lbp_model[a]});
        @(negedge clk);
        checks++;
        if (wr_count !== 14'(N_INNER)) begin
            failures++;
            $display("FAIL wr_count_final: got %0d want %0d", wr_count, N_INNER);
        end
        checks++;
        if ({err, dump_valid, done} !== 3'b000) begin
            failures++;
            $display("FAIL dump_entry_flags: err,dump_valid,done=%b want 000", {err, dump_valid, done});
        end
    endtask

    task automatic test_dump();
        int cyc = 0;
        int beats = 0;
        logic stalled = 1'b0;
        logic [21:0] held = '0;
        logic [21:0] e;
        while (beats < N && cyc < 40000) begin
            @(posedge clk); #1;
            dump_ready = (cyc < 256) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (dump_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL dump_valid_rise: got %b want 1", dump_valid);
                end
            end
            if (stalled) begin
                checks++;
                if ({dump_valid, dump_addr, dump_data} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL dump_hold: got %0h want %0h", {dump_valid, dump_addr, dump_data}, {1'b1, held});
                end
            end
            if (dump_valid && dump_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL dump_extra_beat: addr %0d beyond expected stream", dump_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({dump_addr, dump_data} !== e) begin
                        failures++;
                        $display("FAIL dump_beat: addr,data=%0d,%0h want %0d,%0h", dump_addr, dump_data, e[21:8], e[7:0]);
                    end
                end
                beats++;
            end
            stalled = dump_valid && !dump_ready;
            held    = {dump_addr, dump_data};
            cyc++;
        end
        checks++;
        if (beats != N) begin
            failures++;
            $display("FAIL dump_timeout: got %0d beats want %0d", beats, N);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({done, dump_valid} !== 2'b10) begin
            failures++;
            $display("FAIL done_after_dump: done,dump_valid=%b want 10", {done, dump_valid});
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL dump_missing: %0d beats left want 0", exp_q.size());
        end
    endtask

    task automatic test_restart_from_done();
        @(posedge clk); #1;
        start_pulse();
        @(negedge clk);
        checks++;
        if ({done, load_ready, err, wr_count} !== {1'b0, 1'b1, 1'b0, 14'd0}) begin
            failures++;
            $display("FAIL restart_from_done: done,load_ready,err,wr_count=%0h want %0h",
                     {done, load_ready, err, wr_count}, {1'b0, 1'b1, 15'd0});
        end
    endtask

    initial begin
        test_reset();
        test_err_outside_serve();
        test_load_ramp();
        test_gray_read();
        test_host_stall();
        test_border_write();
        test_reset_mid_load();
        test_full_run();
        test_dump();
        test_restart_from_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lbp_img_host.md
Name: lbp_img_host

Overview:
Memory-side responder for the LBP engine's gray-read / lbp-write interface. It accepts a 128x128 8-bit gray image over a load stream and serves the engine's gray_addr/gray_req reads. It captures the engine's lbp_addr/lbp_valid writes into a result store. After the engine raises finish, it streams the full 128x128 LBP result out over a valid/ready dump port. It is the host/bench-side partner that lets the LBP core run standalone in simulation and on FPGA.

Parameters:
IMG_W, 128, image width in pixels (power of 2)
IMG_H, 128, image height in pixels
AW, 14, address width, log2(IMG_W*IMG_H)
DW, 8, pixel/LBP data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins LOAD from IDLE or DONE
load_valid  in  1  load beat valid
load_ready  out  1  high in LOAD; a beat transfers when load_valid&&load_ready
load_data  in  DW  gray pixel, row-major, address 0 first
host_stall  in  1  forces gray_ready low (wait-state injection)
gray_addr  in  AW  engine read address
gray_req  in  1  engine read request
gray_ready  out  1  responder ready to serve reads
gray_data  out  DW  gray pixel at gray_addr
lbp_addr  in  AW  engine write address
lbp_valid  in  1  engine write strobe
lbp_data  in  DW  LBP code
finish  in  1  engine completion
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump sink ready
dump_addr  out  AW  address of current dump beat
dump_data  out  DW  LBP result at dump_addr
wr_count  out  AW  number of accepted lbp writes
done  out  1  high in DONE
err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: load_ready=0, gray_ready=0, gray_data=0, dump_valid=0, dump_addr=0, dump_data=0, wr_count=0, done=0, err=0, FSM=IDLE. Memory contents are not reset.
- FSM IDLE: start -> LOAD; clear wr_count and err.
- FSM LOAD: load_ready=1. Each transfer writes gray_mem[ld_ptr] and increments ld_ptr. After the transfer at ld_ptr=IMG_W*IMG_H-1 -> SERVE, with ld_ptr wrapped to 0.
- FSM SERVE: gray_ready is registered and equals !host_stall; it is high from the first SERVE cycle when host_stall=0. Asserting host_stall drops gray_ready on the next cycle.
- FSM SERVE, then: finish sampled high -> DUMP. A write on the same cycle as finish is still captured.
- FSM DUMP, then: DONE after the beat at dump_addr=IMG_W*IMG_H-1 transfers (dump_valid&&dump_ready).
- FSM DONE: done=1. start -> LOAD.
- Read path: gray_data = gray_mem[gray_addr], asynchronous read, valid in the same cycle. The engine samples it at the next edge.
  - The read is independent of gray_req.
  - Outside SERVE, gray_data=0.
  - gray_req=1 outside SERVE sets err.
- Write path, in SERVE: lbp_valid=1 writes lbp_mem[lbp_addr] <= lbp_data at the edge and increments wr_count (saturating at 2^AW-1).
  - lbp_valid outside SERVE: ignored and sets err.
  - lbp_valid to a border address (row 0, row IMG_H-1, col 0, col IMG_W-1): not stored, and sets err.
- Dump path:
  - dump_valid rises the cycle after DUMP entry.
  - dump_data and dump_addr are registered and stay stable while dump_valid && !dump_ready.
  - dump_data is forced to 0 for border addresses; otherwise it is lbp_mem[dump_addr] via a 1-cycle prefetch.
  - Back-to-back beats are supported: throughput is 1 beat/cycle when dump_ready=1.
- Finish check: on DUMP entry, err is set if wr_count != (IMG_W-2)*(IMG_H-2), which is 15876 for the defaults.
- err is sticky until the next start or reset.
- Reset mid-operation: FSM returns to IDLE and all outputs take their reset values. Memories keep their contents, but a new image must be loaded.
- Address arithmetic: AW-bit unsigned. Row = addr[AW-1:log2(IMG_W)], col = addr[log2(IMG_W)-1:0].

Decomposition:
- Package lbp_pkg holds:
  - IMG_W, IMG_H, AW, DW constants
  - FSM state enum {IDLE, LOAD, SERVE, DUMP, DONE}
  - N_PIX and N_INNER constants
  - is_border(addr) function
- Sub-module lbp_host_ram: DW x 2^AW array with one sync write port and one async read port. Instantiated twice, for gray_mem and lbp_mem.

Test Plan:
- Load ramp (pixel[a]=a[7:0]), drive gray_addr=129 in SERVE -> gray_data=0x81 in the same cycle; gray_ready=1 one cycle after the last load beat.
- host_stall=1 for 3 cycles in SERVE -> gray_ready low for exactly 3 cycles, starting one cycle later; gray_data is still valid throughout.
- Connect the LBP engine with a constant image (all 0x40), run to finish -> wr_count=15876, err=0, every inner dump_data=0xFF, border dump_data=0x00.
- Write lbp_addr=0 (border) with lbp_valid in SERVE -> err=1, lbp_mem unchanged, wr_count unchanged.
- Dump with dump_ready toggling 1,0,0,1 -> dump_addr/dump_data stay stable while stalled; addresses 0..16383 appear in order with no gaps or duplicates; done=1 after beat 16383.
- Assert reset in the middle of LOAD (after 5000 beats), then start -> load_ready=1, ld_ptr restarts at 0, err=0, wr_count=0.
